// File: rtl/puf_pkg.sv
// Shared constants for the emulated ring-oscillator PUF: RO count, half-period table, counter width, FSM states.
// No logic; latency and backpressure not applicable.
// Half-period table stands in for process variation between oscillators.
package puf_pkg;

    localparam int NUM_RO  = 8;
    localparam int COUNT_W = 16;

    localparam int RO_HALF [NUM_RO] = '{5, 7, 6, 9, 4, 8, 11, 10};

    typedef enum logic {
        ST_MEASURE = 1'b0,
        ST_COMPARE = 1'b1
    } state_t;

    function automatic int ro_half(input int idx);
        return RO_HALF[idx];
    endfunction

endpackage

// File: rtl/ro_emulator.sv
// Emulated ring oscillator: toggles a wave every HALF_PERIOD run cycles and counts 0->1 transitions.
// Count updates in the same cycle as the rising toggle; no pipeline.
// No backpressure: run gates progress, clear and rst zero all state.
module ro_emulator
    import puf_pkg::*;
#(
    parameter int HALF_PERIOD = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               clear,
    output logic [COUNT_W-1:0] edge_count
);

    localparam int PH_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    logic [PH_W-1:0] phase;
    logic            wave;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase      <= '0;
            wave       <= 1'b0;
            edge_count <= '0;
        end else if (run) begin
            if (phase == PH_LAST) begin
                phase <= '0;
                wave  <= ~wave;
                // Only the 0->1 toggle counts; saturate so a long window never wraps.
                if (!wave && (edge_count != {COUNT_W{1'b1}})) begin
                    edge_count <= edge_count + 1'b1;
                end
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/project.sv
// RO-PUF response generator: races two emulated oscillators over a fixed window, outputs A-faster bit.
// Output updates once per WINDOW_CYCLES+1 cycles, on the COMPARE edge; holds otherwise.
// No backpressure; free-running from reset release.
module project
    import puf_pkg::*;
#(
    parameter int WINDOW_CYCLES = 256,
    parameter int SEL_A         = 0,
    parameter int SEL_B         = 1
) (
    input  logic clk,
    input  logic rst,
    output logic puf_bit_out
);

    localparam logic [COUNT_W-1:0] WIN_LAST = COUNT_W'(WINDOW_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [COUNT_W-1:0] win_cnt;
    logic               measure;
    logic               clear;
    logic [COUNT_W-1:0] count_a;
    logic [COUNT_W-1:0] count_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_MEASURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        measure   = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_MEASURE: begin
                measure = 1'b1;
                if (win_cnt == WIN_LAST) begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                clear     = 1'b1;
                state_nxt = ST_MEASURE;
            end
            default: state_nxt = ST_MEASURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_cnt <= '0;
        end else if (measure) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    // Strict greater-than: a tie resolves to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            puf_bit_out <= 1'b0;
        end else if (state == ST_COMPARE) begin
            puf_bit_out <= (count_a > count_b);
        end
    end

    ro_emulator #(
        .HALF_PERIOD(ro_half(SEL_A))
    ) u_ro_a (
        .clk       (clk),
        .rst       (rst),
        .run       (measure),
        .clear     (clear),
        .edge_count(count_a)
    );

    ro_emulator #(
        .HALF_PERIOD(ro_half(SEL_B))
    ) u_ro_b (
        .clk       (clk),
        .rst       (rst),
        .run       (measure),
        .clear     (clear),
        .edge_count(count_b)
    );

endmodule

// File: tb/tb_project.sv
// Bench for project: four parameterisations share clk/rst; outputs checked every cycle and at table points.
module tb_project;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit0, bit1, bit2, bit3;

    always #5 clk = ~clk;

    // d0: defaults (H5 vs H7, W256) -> 26 vs 18 -> 1
    project u_d0 (.clk(clk), .rst(rst), .puf_bit_out(bit0));
    // d1: swapped (H7 vs H5, W256) -> 18 vs 26 -> 0
    project #(.SEL_A(1), .SEL_B(0)) u_d1 (.clk(clk), .rst(rst), .puf_bit_out(bit1));
    // d2: tie (H7 vs H6, W16) -> 1 vs 1 -> 0
    project #(.WINDOW_CYCLES(16), .SEL_A(1), .SEL_B(2)) u_d2 (.clk(clk), .rst(rst), .puf_bit_out(bit2));
    // d3: short window (H5 vs H7, W16) -> 2 vs 1 -> 1 from edge 17
    project #(.WINDOW_CYCLES(16)) u_d3 (.clk(clk), .rst(rst), .puf_bit_out(bit3));

    int n_cmp   = 0;
    int n_bad   = 0;
    int edge_no = 0;

    typedef struct {
        int   edge_at;
        logic e0;
        logic e1;
        logic e2;
        logic e3;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0b want=%0b", name, edge_no, act, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge against the expected waveform.
    task automatic step_check();
        @(posedge clk);
        @(negedge clk);
        if (rst) edge_no = 0;
        else     edge_no++;
        check("cyc_d0", bit0, (!rst) && (edge_no >= 257));
        check("cyc_d1", bit1, 1'b0);
        check("cyc_d2", bit2, 1'b0);
        check("cyc_d3", bit3, (!rst) && (edge_no >= 17));
    endtask

    initial begin
        tbl[0]  = '{16,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{17,   1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{256,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{257,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{258,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{514,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{771,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1028, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1285, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1542, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1799, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{2000, 1'b1, 1'b0, 1'b0, 1'b1};

        // Two reset edges, all outputs 0.
        rst = 1'b1;
        step_check();
        step_check();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            while (edge_no < tbl[i].edge_at) step_check();
            check("tbl_d0", bit0, tbl[i].e0);
            check("tbl_d1", bit1, tbl[i].e1);
            check("tbl_d2", bit2, tbl[i].e2);
            check("tbl_d3", bit3, tbl[i].e3);
        end

        // Mid-operation reset at cycle 400 of a fresh run.
        rst = 1'b1;
        step_check();
        rst = 1'b0;
        while (edge_no < 400) step_check();
        check("pre_rst_d0", bit0, 1'b1);
        rst = 1'b1;
        step_check();
        check("mid_rst_d0", bit0, 1'b0);
        check("mid_rst_d3", bit3, 1'b0);
        rst = 1'b0;
        while (edge_no < 256) step_check();
        check("post_rst_256_d0", bit0, 1'b0);
        step_check();
        check("post_rst_257_d0", bit0, 1'b1);
        while (edge_no < 300) step_check();
        check("post_rst_300_d0", bit0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/project.md
PROJECT -- requirements
Module: project

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 256, length of one measurement window in clock cycles (legal 16..65535).
REQ-002 SHALL have parameter SEL_A, default 0, index (0..7) of emulated ring oscillator A.
REQ-003 SHALL have parameter SEL_B, default 1, index (0..7) of emulated ring oscillator B; SEL_A != SEL_B.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port puf_bit_out  output  1  registered PUF response bit.
REQ-007 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-008 SHALL model 8 emulated ring oscillators (RO), each with fixed half-period H[i] in clk cycles: H = {5,7,6,9,4,8,11,10} for i = 0..7 (emulated process variation).
REQ-009 Each RO SHALL hold a phase counter (0..H-1), a wave bit, and a 16-bit rising-edge counter.
REQ-010 On each MEASURE edge, each RO SHALL increment phase; when phase equals H-1 it SHALL wrap to 0 and toggle wave; a 0->1 toggle SHALL increment the edge counter (saturating at 65535).
REQ-011 Control FSM SHALL have two states: MEASURE and COMPARE.
REQ-012 MEASURE SHALL last exactly WINDOW_CYCLES edges, counted by a 16-bit window counter.
REQ-013 After the WINDOW_CYCLES-th MEASURE edge, the next edge SHALL be COMPARE: puf_bit_out <= (count[SEL_A] > count[SEL_B]); ties SHALL yield 0.
REQ-014 In COMPARE, all RO phase, wave and edge counters and the window counter SHALL clear to 0; the next edge returns to MEASURE.
REQ-015 Window period SHALL be WINDOW_CYCLES+1 cycles; each window restarts from identical state, so the response is repeatable.
REQ-016 puf_bit_out SHALL change only on COMPARE edges (or reset) and SHALL hold between them.
REQ-017 With defaults, the first update SHALL occur on the 257th rising edge after rst deasserts (edges 1..256 MEASURE, 257 COMPARE).
REQ-018 Only ROs SEL_A and SEL_B need be instantiated; unused ones may be omitted.

Reset
REQ-019 While rst=1 at a rising edge: puf_bit_out=0, FSM=MEASURE, window counter and all RO state = 0.
REQ-020 Reset asserted mid-window or during COMPARE SHALL abort the window with no output update other than clearing to 0.
REQ-021 The first edge with rst=0 SHALL be MEASURE edge 1.

Structure
REQ-022 Package puf_pkg SHALL hold NUM_RO=8, the H[] table, COUNT_W=16, and the FSM state enum.
REQ-023 One sub-module ro_emulator (param HALF_PERIOD; inputs clk, rst, run, clear; output 16-bit edge_count) SHALL implement REQ-009/010.

Verification
REQ-024 Reset: rst=1 for 2 cycles, then 0 -> puf_bit_out=0 during reset and through edge 256 after release.
REQ-025 Defaults (H 5 vs 7, W=256): counts 26 vs 18 -> puf_bit_out=1 from edge 257 and still 1 at 2000 cycles (20 us at 100 MHz).
REQ-026 SEL_A=1, SEL_B=0, W=256: 18 vs 26 -> puf_bit_out stays 0 for 2000 cycles.
REQ-027 Tie: SEL_A=1, SEL_B=2, WINDOW_CYCLES=16: counts 1 vs 1 -> puf_bit_out=0 after edge 17 and every window.
REQ-028 Reset mid-op: defaults, assert rst for 1 cycle at cycle 400 -> output 0 next edge, returns to 1 on the 257th edge after release.
REQ-029 Repeatability: defaults, sample puf_bit_out after each of 7 consecutive COMPARE edges -> all 1, no glitches between.
